ula_181_acc: RTL

Registered, parametrised successor to the 4-bit 74181-style ALU. It keeps the 16 logic and 16 arithmetic functions selected by M/S and extends them to WIDTH bits (a multiple of 4). It adds a valid/ready handshake, an internal accumulator, and a carry flag register for multi-word chaining. It sits between an operand-issuing controller and the result consumer in datapath exercises.

---
 rtl/ula_181_acc_if.sv | 36 +++
 rtl/ula_181_acc.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ula_181_acc_if.sv
// Handshake and operand/result bundle for the registered 181-style ALU.
// The controller side (master) issues operations and consumes results;
// the ALU side (slave) accepts operations and presents registered results.
interface ula_181_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             M;
    logic [3:0]       S;
    logic             Cn;
    logic             use_acc;
    logic             use_cf;
    logic             wr_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             Cn4;
    logic             OVF;
    logic             Z;
    logic             AeqB;
    logic [WIDTH-1:0] acc_q;
    logic             cf_q;

    modport master (
        output in_valid, A, B, M, S, Cn, use_acc, use_cf, wr_acc, out_ready,
        input  in_ready, out_valid, F, Cn4, OVF, Z, AeqB, acc_q, cf_q
    );

    modport slave (
        input  in_valid, A, B, M, S, Cn, use_acc, use_cf, wr_acc, out_ready,
        output in_ready, out_valid, F, Cn4, OVF, Z, AeqB, acc_q, cf_q
    );
endinterface

// File: rtl/ula_181_acc.sv
// Registered WIDTH-bit 74181-style ALU with accumulator and carry flag.
//
// state | meaning
// EMPTY | no unconsumed result; out_valid = 0
// FULL  | result registers hold an unconsumed result; out_valid = 1
module ula_181_acc #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    ula_181_acc_if.slave bus
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state_q, state_d;

    logic             accept;
    logic [WIDTH-1:0] ae;
    logic             ci;
    logic [WIDTH-1:0] logic_f;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sum_low;
    logic             c_msb;
    logic [WIDTH-1:0] f_d;
    logic             cn4_d;
    logic             ovf_d;

    logic [WIDTH-1:0] f_q;
    logic             cn4_q;
    logic             ovf_q;
    logic             z_q;
    logic             aeqb_q;
    logic [WIDTH-1:0] acc_r;
    logic             cf_r;

    assign accept = bus.in_valid && bus.in_ready;

    // Effective operands: the accumulator and carry flag are the values held
    // before the accepting edge, so back-to-back accumulate ops chain cleanly.
    assign ae = bus.use_acc ? acc_r : bus.A;
    assign ci = bus.use_cf ? cf_r : bus.Cn;

    // Logic-mode function table (M = 1).
    always_comb begin
        logic_f = '0;
        unique case (bus.S)
            4'b0000: logic_f = ~ae;
            4'b0001: logic_f = ~(ae | bus.B);
            4'b0010: logic_f = ~ae & bus.B;
            4'b0011: logic_f = '0;
            4'b0100: logic_f = ~(ae & bus.B);
            4'b0101: logic_f = ~bus.B;
            4'b0110: logic_f = ae ^ bus.B;
            4'b0111: logic_f = ae & ~bus.B;
            4'b1000: logic_f = ~ae | bus.B;
            4'b1001: logic_f = ~(ae ^ bus.B);
            4'b1010: logic_f = bus.B;
            4'b1011: logic_f = ae & bus.B;
            4'b1100: logic_f = '1;
            4'b1101: logic_f = ae | ~bus.B;
            4'b1110: logic_f = ae | bus.B;
            4'b1111: logic_f = ae;
            default: logic_f = '0;
        endcase
    end

    // Arithmetic-mode addend selection (M = 0): F = P + Q + ci.
    always_comb begin
        p = ae;
        q = '0;
        unique case (bus.S)
            4'b0000: begin p = ae;            q = '0;             end
            4'b0001: begin p = ae | bus.B;    q = '0;             end
            4'b0010: begin p = ae | ~bus.B;   q = '0;             end
            4'b0011: begin p = '0;            q = '1;             end
            4'b0100: begin p = ae;            q = ae & ~bus.B;    end
            4'b0101: begin p = ae | bus.B;    q = ae & ~bus.B;    end
            4'b0110: begin p = ae;            q = ~bus.B;         end
            4'b0111: begin p = ae & ~bus.B;   q = '1;             end
            4'b1000: begin p = ae;            q = ae & bus.B;     end
            4'b1001: begin p = ae;            q = bus.B;          end
            4'b1010: begin p = ae | ~bus.B;   q = ae & bus.B;     end
            4'b1011: begin p = ae & bus.B;    q = '1;             end
            4'b1100: begin p = ae;            q = ae;             end
            4'b1101: begin p = ae | bus.B;    q = ae;             end
            4'b1110: begin p = ae | ~bus.B;   q = ae;             end
            4'b1111: begin p = ae;            q = '1;             end
            default: begin p = ae;            q = '0;             end
        endcase
    end

    // Full sum plus a separate sum of the low bits to recover the carry into
    // the MSB; signed overflow is that carry disagreeing with the carry-out.
    assign sum     = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, ci};
    assign sum_low = {1'b0, p[WIDTH-2:0]} + {1'b0, q[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, ci};
    assign c_msb   = sum_low[WIDTH-1];

    // Result and flag mux between logic and arithmetic modes.
    always_comb begin
        f_d   = sum[WIDTH-1:0];
        cn4_d = sum[WIDTH];
        ovf_d = c_msb ^ sum[WIDTH];
        if (bus.M) begin
            f_d   = logic_f;
            cn4_d = 1'b0;
            ovf_d = 1'b0;
        end
    end

    // Result, flag, accumulator and carry-flag registers; load only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= '0;
            cn4_q  <= 1'b0;
            ovf_q  <= 1'b0;
            z_q    <= 1'b0;
            aeqb_q <= 1'b0;
            acc_r  <= ACC_INIT;
            cf_r   <= 1'b0;
        end else if (accept) begin
            f_q    <= f_d;
            cn4_q  <= cn4_d;
            ovf_q  <= ovf_d;
            z_q    <= (f_d == '0);
            aeqb_q <= (ae == bus.B);
            if (!bus.M) begin
                cf_r <= cn4_d;
            end
            if (bus.wr_acc) begin
                acc_r <= f_d;
            end
        end
    end

    // Output-register occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an accept always leaves a fresh result; a lone consume empties.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    // Handshake outputs; a consume in the same cycle frees the slot for accept.
    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = (state_q == EMPTY) || bus.out_ready;
    end

    assign bus.F     = f_q;
    assign bus.Cn4   = cn4_q;
    assign bus.OVF   = ovf_q;
    assign bus.Z     = z_q;
    assign bus.AeqB  = aeqb_q;
    assign bus.acc_q = acc_r;
    assign bus.cf_q  = cf_r;

endmodule
